// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and widths for the time-shared neuron layer sequencer.
package neuron_layer_sequencer_pkg;

    localparam int unsigned BROJ_ULAZA_DEF   = 5;
    localparam int unsigned BROJ_NEURONA_DEF = 2;

    localparam int unsigned TEZINA_W   = 19;
    localparam int unsigned UZORAK_W   = 16;
    localparam int unsigned SUMA_W     = 22;
    localparam int unsigned ACC_W      = 24;
    localparam int unsigned IZLAZ_W    = 16;
    localparam int unsigned CFG_ADDR_W = 4;
    localparam int unsigned PROD_W     = TEZINA_W - 1;

    localparam logic [SUMA_W-1:0] SUMA_SAT = 22'h3FFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_SIGM = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/Sigmoid_LUT.sv
// Combinational piecewise-linear sigmoid: Q6.16 magnitude plus sign in, Q0.16 probability out.
module Sigmoid_LUT (
    input  logic [21:0] suma,
    input  logic        predznak,
    output logic [15:0] vjerojatnost
);

    logic [16:0] y;
    logic [15:0] poz;

    // Segments break at |x| = 1.0, 2.375 and 5.0; y(-x) = 1 - y(x).
    always_comb begin
        y = 17'h0FFFF;
        if (suma >= 22'h050000) begin
            y = 17'h0FFFF;
        end else if (suma >= 22'h026000) begin
            y = 17'(suma >> 5) + 17'h0D800;
        end else if (suma >= 22'h010000) begin
            y = 17'(suma >> 3) + 17'h0A000;
        end else begin
            y = 17'(suma >> 2) + 17'h08000;
        end
        poz          = y[16] ? 16'hFFFF : y[15:0];
        vjerojatnost = predznak ? 16'(17'h10000 - {1'b0, poz}) : poz;
    end

endmodule

// File: rtl/signed_mac_jedinica.sv
// Sign-magnitude weight x unsigned sample multiply-accumulate with abs/saturate view of the sum.
module signed_mac_jedinica
    import neuron_layer_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [TEZINA_W-1:0] tezina_i,
    input  logic [UZORAK_W-1:0] uzorak_i,
    output logic [SUMA_W-1:0]   suma_c_o,
    output logic                predznak_c_o
);

    localparam int unsigned PUNI_W = PROD_W + UZORAK_W;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PUNI_W-1:0] puni;
    logic [PROD_W-1:0] mag;
    logic [ACC_W-1:0]  clan;
    logic [ACC_W-1:0]  aps;

    always_comb begin
        puni  = PUNI_W'(tezina_i[PROD_W-1:0]) * PUNI_W'(uzorak_i);
        mag   = PROD_W'(puni >> UZORAK_W);
        clan  = tezina_i[TEZINA_W-1] ? -ACC_W'(mag) : ACC_W'(mag);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + clan;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Magnitude of the accumulator, clipped to the LUT input range.
    always_comb begin
        predznak_c_o = acc_q[ACC_W-1];
        aps          = predznak_c_o ? -acc_q : acc_q;
        suma_c_o     = (|aps[ACC_W-1:SUMA_W]) ? SUMA_SAT : aps[SUMA_W-1:0];
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one shared MAC and sigmoid LUT over all neurons of a small layer.
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int unsigned BROJ_ULAZA   = BROJ_ULAZA_DEF,
    parameter int unsigned BROJ_NEURONA = BROJ_NEURONA_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [UZORAK_W*BROJ_ULAZA-1:0]   uzorak,
    input  logic                             ulaz_valid,
    output logic                             ulaz_ready,
    input  logic                             cfg_we,
    input  logic [CFG_ADDR_W-1:0]            cfg_addr,
    input  logic [TEZINA_W-1:0]              cfg_data,
    output logic                             cfg_err,
    output logic [IZLAZ_W*BROJ_NEURONA-1:0]  izlaz,
    output logic                             izlaz_valid,
    input  logic                             izlaz_ready
);

    localparam int unsigned BROJ_TEZINA = BROJ_ULAZA * BROJ_NEURONA;
    localparam int unsigned UL_CNT_W    = (BROJ_ULAZA > 1) ? $clog2(BROJ_ULAZA) : 1;
    localparam int unsigned NE_CNT_W    = (BROJ_NEURONA > 1) ? $clog2(BROJ_NEURONA) : 1;
    localparam logic [UL_CNT_W-1:0] ZADNJI_UL = UL_CNT_W'(BROJ_ULAZA - 1);
    localparam logic [NE_CNT_W-1:0] ZADNJI_NE = NE_CNT_W'(BROJ_NEURONA - 1);

    state_e state_q, state_d;

    logic [UL_CNT_W-1:0]              ulaz_idx_q;
    logic [NE_CNT_W-1:0]              neuron_q;
    logic [UZORAK_W*BROJ_ULAZA-1:0]   uzorak_q;
    logic [TEZINA_W-1:0]              tezine_q [BROJ_TEZINA];
    logic [IZLAZ_W*BROJ_NEURONA-1:0]  izlaz_q;
    logic                             izlaz_valid_q;
    logic                             cfg_err_q;

    logic                  prihvat_c;
    logic                  upis_ok_c;
    logic                  mac_en_c;
    logic                  sigm_c;
    logic [CFG_ADDR_W-1:0] tez_idx_c;
    logic [TEZINA_W-1:0]   tezina_c;
    logic [UZORAK_W-1:0]   uzorak_sel_c;
    logic [SUMA_W-1:0]     suma_c;
    logic                  predznak_c;
    logic [IZLAZ_W-1:0]    vjerojatnost_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ulaz_valid) state_d = S_MAC;
            S_MAC:   if (ulaz_idx_q == ZADNJI_UL) state_d = S_SIGM;
            S_SIGM:  state_d = (neuron_q == ZADNJI_NE) ? S_DONE : S_MAC;
            S_DONE:  if (izlaz_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prihvat_c = 1'b0;
        mac_en_c  = 1'b0;
        sigm_c    = 1'b0;
        case (state_q)
            S_IDLE:  prihvat_c = ulaz_valid && !rst;
            S_MAC:   mac_en_c  = 1'b1;
            S_SIGM:  sigm_c    = 1'b1;
            default: ;
        endcase
    end

    // Writes land only while idle, so a write on the accept edge is seen by the first MAC edge.
    always_comb begin
        upis_ok_c    = cfg_we && (state_q == S_IDLE) && (cfg_addr < CFG_ADDR_W'(BROJ_TEZINA));
        tez_idx_c    = CFG_ADDR_W'(neuron_q) * CFG_ADDR_W'(BROJ_ULAZA) + CFG_ADDR_W'(ulaz_idx_q);
        tezina_c     = tezine_q[tez_idx_c];
        uzorak_sel_c = uzorak_q[UZORAK_W*ulaz_idx_q +: UZORAK_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ulaz_idx_q <= '0;
            neuron_q   <= '0;
            uzorak_q   <= '0;
        end else begin
            if (prihvat_c) begin
                uzorak_q   <= uzorak;
                ulaz_idx_q <= '0;
                neuron_q   <= '0;
            end
            if (mac_en_c) begin
                ulaz_idx_q <= (ulaz_idx_q == ZADNJI_UL) ? '0 : ulaz_idx_q + UL_CNT_W'(1);
            end
            if (sigm_c && (neuron_q != ZADNJI_NE)) begin
                neuron_q <= neuron_q + NE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BROJ_TEZINA); i++) begin
                tezine_q[i] <= '0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            if (upis_ok_c) begin
                tezine_q[cfg_addr] <= cfg_data;
            end
            cfg_err_q <= cfg_we && !upis_ok_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            izlaz_q       <= '0;
            izlaz_valid_q <= 1'b0;
        end else begin
            if (sigm_c) begin
                izlaz_q[IZLAZ_W*neuron_q +: IZLAZ_W] <= vjerojatnost_c;
            end
            if (sigm_c && (neuron_q == ZADNJI_NE)) begin
                izlaz_valid_q <= 1'b1;
            end else if ((state_q == S_DONE) && izlaz_ready) begin
                izlaz_valid_q <= 1'b0;
            end
        end
    end

    signed_mac_jedinica u_mac (
        .clk          (clk),
        .rst          (rst),
        .en_i         (mac_en_c),
        .clr_i        (sigm_c),
        .tezina_i     (tezina_c),
        .uzorak_i     (uzorak_sel_c),
        .suma_c_o     (suma_c),
        .predznak_c_o (predznak_c)
    );

    Sigmoid_LUT u_lut (
        .suma         (suma_c),
        .predznak     (predznak_c),
        .vjerojatnost (vjerojatnost_c)
    );

    assign ulaz_ready  = (state_q == S_IDLE) && !rst;
    assign izlaz       = izlaz_q;
    assign izlaz_valid = izlaz_valid_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with hand-computed sigmoid results.
module tb_neuron_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] uzorak;
    logic        ulaz_valid;
    logic        ulaz_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [18:0] cfg_data;
    logic        cfg_err;
    logic [31:0] izlaz;
    logic        izlaz_valid;
    logic        izlaz_ready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    neuron_layer_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .uzorak      (uzorak),
        .ulaz_valid  (ulaz_valid),
        .ulaz_ready  (ulaz_ready),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .izlaz       (izlaz),
        .izlaz_valid (izlaz_valid),
        .izlaz_ready (izlaz_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [18:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Accept one sample, check the 12-cycle latency and result, then release DONE.
    task automatic run_sample(input string tag, input logic [79:0] s, input logic [31:0] exp);
        ulaz_valid = 1'b1;
        uzorak     = s;
        chk({tag, " ready"}, 32'(ulaz_ready), 32'd1);
        tick();
        ulaz_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("%s valid@E%0d", tag, k), 32'(izlaz_valid), 32'(k == 12));
        end
        chk({tag, " izlaz"}, izlaz, exp);
        izlaz_ready = 1'b1;
        tick();
        izlaz_ready = 1'b0;
        chk({tag, " exit"}, 32'(izlaz_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        uzorak      = '0;
        ulaz_valid  = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        izlaz_ready = 1'b0;

        tick();
        tick();
        chk("rst ulaz_ready", 32'(ulaz_ready), 32'd0);
        chk("rst izlaz", izlaz, 32'd0);
        chk("rst izlaz_valid", 32'(izlaz_valid), 32'd0);
        chk("rst cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ulaz_ready", 32'(ulaz_ready), 32'd1);

        // All weights +1.0, samples 0.5: each neuron sums to 2.5 -> 0xEC00.
        for (int i = 0; i < 10; i++) wr(4'(i), 19'h10000);
        chk("valid writes no err", 32'(cfg_err), 32'd0);
        ulaz_valid = 1'b1;
        uzorak     = {5{16'h8000}};
        tick();
        ulaz_valid = 1'b0;
        chk("busy ulaz_ready", 32'(ulaz_ready), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("half valid@E%0d", k), 32'(izlaz_valid), 32'(k == 12));
        end
        chk("half izlaz", izlaz, 32'hEC00_EC00);

        // Consumer stalls for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hold valid %0d", k), 32'(izlaz_valid), 32'd1);
            chk($sformatf("hold izlaz %0d", k), izlaz, 32'hEC00_EC00);
            chk($sformatf("hold ready %0d", k), 32'(ulaz_ready), 32'd0);
        end

        // A sample offered on the DONE-exit edge must not be taken there.
        izlaz_ready = 1'b1;
        ulaz_valid  = 1'b1;
        uzorak      = {5{16'h4000}};
        tick();
        izlaz_ready = 1'b0;
        chk("exit valid", 32'(izlaz_valid), 32'd0);
        chk("exit ulaz_ready", 32'(ulaz_ready), 32'd1);
        chk("exit izlaz kept", izlaz, 32'hEC00_EC00);
        run_sample("quarter", {5{16'h4000}}, 32'hC800_C800);

        // w0 = -1.0, rest 0; w5 cleared on the accept edge itself.
        for (int i = 0; i < 10; i++) begin
            if (i != 5) wr(4'(i), (i == 0) ? 19'h50000 : 19'h00000);
        end
        cfg_we     = 1'b1;
        cfg_addr   = 4'd5;
        cfg_data   = 19'h00000;
        ulaz_valid = 1'b1;
        uzorak     = 80'h0000_0000_0000_0000_FFFF;
        tick();
        ulaz_valid = 1'b0;
        chk("accept-edge write no err", 32'(cfg_err), 32'd0);
        cfg_addr = 4'd3;
        cfg_data = 19'h10000;
        tick();
        cfg_we = 1'b0;
        chk("mac write err", 32'(cfg_err), 32'd1);
        tick();
        chk("mac write err drop", 32'(cfg_err), 32'd0);
        for (int k = 3; k <= 12; k++) begin
            tick();
            chk($sformatf("neg valid@E%0d", k), 32'(izlaz_valid), 32'(k == 12));
        end
        chk("neg izlaz", izlaz, 32'h8000_4001);
        izlaz_ready = 1'b1;
        tick();
        izlaz_ready = 1'b0;

        wr(4'd12, 19'h10000);
        chk("bad addr err", 32'(cfg_err), 32'd1);
        tick();
        chk("bad addr err drop", 32'(cfg_err), 32'd0);

        // w3 must still be 0; a leaked write would cancel neuron 0 to 0x8000.
        run_sample("no leak", {5{16'hFFFF}}, 32'h8000_4001);

        // Reset on E7 of a computation.
        ulaz_valid = 1'b1;
        uzorak     = {5{16'hFFFF}};
        tick();
        ulaz_valid = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        chk("pre-rst izlaz", izlaz, 32'h8000_4001);
        rst = 1'b1;
        tick();
        chk("mid rst izlaz", izlaz, 32'd0);
        chk("mid rst valid", 32'(izlaz_valid), 32'd0);
        chk("mid rst ready", 32'(ulaz_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("after rst ready", 32'(ulaz_ready), 32'd1);
        run_sample("zero w", {5{16'hFFFF}}, 32'h8000_8000);

        // Largest magnitudes: sum ~20.0 drives the LUT into its saturated ends.
        for (int i = 0; i < 5; i++) wr(4'(i), 19'h3FFFF);
        for (int i = 5; i < 10; i++) wr(4'(i), 19'h7FFFF);
        run_sample("max", {5{16'hFFFF}}, 32'h0001_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
